// File: rtl/keypad_scan_debounce.sv
// Row-scanning keypad front end. It walks one low row per cycle and classifies each full frame.
// It debounces the frame result and emits key events, with optional autorepeat.
module keypad_scan_debounce #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int DB_FRAMES     = 3,
  parameter int REPEAT_FRAMES = 0,
  localparam int CW = ((ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] kp_col,
  output logic [ROWS-1:0] kp_row,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            multi
);

  localparam int RW       = $clog2(ROWS);
  localparam int DBW      = 4;
  localparam int RPW      = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;
  localparam int REP_LAST = (REPEAT_FRAMES > 0) ? REPEAT_FRAMES - 1 : 0;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_MULTI   = 2'd2
  } state_e;

  logic [RW-1:0]  row_q, row_d;
  res_e           acc_kind_q, acc_kind_d;
  logic [CW-1:0]  acc_code_q, acc_code_d;
  res_e           cand_kind_q, cand_kind_d;
  logic [CW-1:0]  cand_code_q, cand_code_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  state_e         state_q, state_d;
  logic [CW-1:0]  key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;
  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;

  logic [COLS-1:0] col_hit;
  logic [1:0]      samp_cnt;
  logic [CW-1:0]   samp_code;
  res_e            merged_kind;
  logic [CW-1:0]   merged_code;
  logic            frame_end;
  state_e          target;
  logic            stable_change;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign col_hit[gi] = ~kp_col[gi];
    end
  endgenerate

  assign frame_end = (row_q == RW'(ROWS - 1));

  // Per-sample zero count saturates at 2: only none/one/many matters.
  always_comb begin
    samp_cnt  = 2'd0;
    samp_code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_hit[c]) begin
        if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
        samp_code = CW'(int'(row_q) * COLS + c);
      end
    end
  end

  // Fold this sample into the partial frame; codes are forced to 0 unless SINGLE
  // so that candidate comparison can be a plain equality on kind and code.
  always_comb begin
    merged_kind = RES_MULTI;
    merged_code = '0;
    case (acc_kind_q)
      RES_NONE: begin
        if (samp_cnt == 2'd0) begin
          merged_kind = RES_NONE;
        end else if (samp_cnt == 2'd1) begin
          merged_kind = RES_SINGLE;
          merged_code = samp_code;
        end
      end
      RES_SINGLE: begin
        if (samp_cnt == 2'd0) begin
          merged_kind = RES_SINGLE;
          merged_code = acc_code_q;
        end
      end
      default: begin
        merged_kind = RES_MULTI;
      end
    endcase
  end

  always_comb begin
    row_d       = frame_end ? '0 : row_q + RW'(1);
    acc_kind_d  = frame_end ? RES_NONE : merged_kind;
    acc_code_d  = frame_end ? '0 : merged_code;
    cand_kind_d = cand_kind_q;
    cand_code_d = cand_code_q;
    db_cnt_d    = db_cnt_q;
    if (frame_end) begin
      if (merged_kind == cand_kind_q && merged_code == cand_code_q) begin
        if (db_cnt_q != DBW'(DB_FRAMES)) db_cnt_d = db_cnt_q + DBW'(1);
      end else begin
        cand_kind_d = merged_kind;
        cand_code_d = merged_code;
        db_cnt_d    = DBW'(1);
      end
    end
  end

  always_comb begin
    case (cand_kind_d)
      RES_SINGLE: target = ST_PRESSED;
      RES_MULTI:  target = ST_MULTI;
      default:    target = ST_IDLE;
    endcase
    // A different code while already pressed counts as a new press.
    stable_change = (db_cnt_d == DBW'(DB_FRAMES)) &&
                    ((target != state_q) ||
                     (target == ST_PRESSED && cand_code_d != key_code_q));
  end

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    if (frame_end) begin
      if (stable_change) begin
        state_d   = target;
        rep_cnt_d = '0;
        if (target == ST_PRESSED) begin
          key_code_d  = cand_code_d;
          key_valid_d = 1'b1;
        end
      end else if (REPEAT_FRAMES > 0 && state_q == ST_PRESSED) begin
        if (rep_cnt_q == RPW'(REP_LAST)) begin
          rep_cnt_d   = '0;
          key_valid_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RPW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q       <= '0;
      acc_kind_q  <= RES_NONE;
      acc_code_q  <= '0;
      cand_kind_q <= RES_NONE;
      cand_code_q <= '0;
      db_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      row_q       <= row_d;
      acc_kind_q  <= acc_kind_d;
      acc_code_q  <= acc_code_d;
      cand_kind_q <= cand_kind_d;
      cand_code_q <= cand_code_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  assign kp_row    = ~(ROWS'(1) << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_PRESSED);
  assign multi     = (state_q == ST_MULTI);

endmodule
